tlb_victim_alloc: RTL
=====================

# tlb_victim_alloc

Entry allocator for a fully associative TLB/cache bank, sitting directly upstream of the PLRU tree, which is instantiated inside this block. It merges lookup hits and refill completions into the tree's one-hot use vector and tracks per-entry valid bits. It picks a victim for each miss: the lowest-index invalid entry first, otherwise the PLRU entry. It holds that victim stable through a request/lock/fill handshake with the refill engine.

## Interface
- ENTRIES, 16, number of entries; power of two, at least 2.
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous and active-high.
- hit_valid_i  in  1  lookup hit this cycle.
- hit_way_i  in  ENTRIES  one-hot hit entry; qualified by hit_valid_i.
- alloc_req_i  in  1  refill engine requests a victim.
- alloc_ack_o  out  1  one-cycle pulse: victim accepted and locked.
- alloc_way_o  out  ENTRIES  one-hot locked victim; stable while busy_o.
- busy_o  out  1  a victim is locked and a fill is outstanding.
- fill_done_i  in  1  refill written to the locked entry; ignored unless busy_o.
- flush_i  in  1  invalidate all entries and abort any outstanding fill.
- valid_o  out  ENTRIES  per-entry valid bits.

## Operation
- States: IDLE, LOCK. Reset and flush_i go to IDLE.
- IDLE, alloc_req_i=1, flush_i=0:
  - Victim = lowest-index zero bit of valid_o if any, else the tree's plru_o.
  - Victim is registered into alloc_way_o; alloc_ack_o pulses; next state LOCK.
- LOCK:
  - alloc_req_i is ignored.
  - fill_done_i=1 sets valid_o[victim], drives the victim onto the tree's used vector, and returns to IDLE.
- Hit masking: a hit is dropped if its entry has valid=0, or if its entry is the locked victim during LOCK.
- Tree use vector: fill pulse if present; otherwise the masked hit; otherwise zero. It is always one-hot or zero. A fill and a hit in the same cycle: fill wins and the hit update is dropped.
- flush_i outranks everything in its cycle:
  - valid_o is cleared and state goes to IDLE.
  - The use vector is zero.
  - A coincident fill_done_i or alloc_req_i is discarded.
- Tree state has no reset. Until every entry is valid, selection takes the invalid-first path. Filling all ENTRIES entries writes every tree node, so plru_o is defined whenever it is used.
- Multi-hot hit_way_i is illegal; a bench assertion flags it.

## Timing
- Reset values: valid_o=0, busy_o=0, alloc_ack_o=0, alloc_way_o=0, state IDLE.
- Request to lock: alloc_req_i sampled at edge N gives alloc_ack_o, busy_o and alloc_way_o valid from N+1. alloc_ack_o lasts exactly one cycle.
- Back-to-back allocation: alloc_req_i held high re-requests in the cycle after fill completion (IDLE), so the minimum spacing is 2 cycles per allocation.
- Fill to valid: fill_done_i at edge M gives valid_o bit set and busy_o=0 from M+1. The tree update is visible in plru_o from M+1.
- Hit to tree: 1-cycle latency (the tree register).
- Victim selection reads plru_o combinationally in IDLE. A hit in the same cycle does not affect that cycle's choice.
- Reset mid-LOCK: back to IDLE next edge; a late fill_done_i is ignored.

## Structure
- Package tlb_alloc_pkg:
  - alloc_state_e (IDLE, LOCK).
  - Function first_zero_onehot(logic [N-1:0]) returning a one-hot result, or zero if there is no zero bit.
- Sub-module: plru_tree, one instance, ENTRIES passed through. Its reset input is tied to the block's reset level; it is unused inside the tree.
- All other state (valid bits, locked victim, FSM) is local flops.

## Test plan
- Cold fill, ENTRIES=4: reset, 4 allocate+fill rounds -> alloc_way_o = 0001, 0010, 0100, 1000; valid_o=1111.
- PLRU victim: after cold fill, hits on entries 0, 2, 1 in consecutive cycles, then allocate -> alloc_way_o=1000. Hit entry 3, then allocate -> alloc_way_o=0001.
- Simultaneous fill and hit: LOCK on entry 2, fill_done_i with a hit on entry 0 in the same cycle. Required: valid[2] set; only entry 2 marked used; entry 0 tree nodes unchanged.
- Locked-victim hit: hit on the locked entry during LOCK -> tree unchanged; alloc_way_o stable; fill completes normally.
- Flush abort: flush_i together with fill_done_i in LOCK -> valid_o=0, busy_o=0 next cycle. Next allocate -> 0001.
- Mid-op reset: rst asserted in LOCK, then fill_done_i -> busy_o=0, valid_o=0, no ack, valid unchanged.

Source files
------------

// File: rtl/tlb_alloc_pkg.sv
// Shared types and helpers for the TLB victim allocator.
// Latency: n/a (types and a purely combinational helper).
// Backpressure: n/a.
package tlb_alloc_pkg;

    // Allocator FSM: IDLE accepts a request, LOCK holds the victim until fill or flush.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOCK = 1'b1
    } alloc_state_e;

    // Widest valid vector the free-entry search supports; callers pad unused bits with ones.
    localparam int FZ_W = 64;

    // One-hot of the lowest-index zero bit, or all zeros when every bit is set.
    // Adding one ripples through the trailing ones and lands on the first zero.
    function automatic logic [FZ_W-1:0] first_zero_onehot(input logic [FZ_W-1:0] vec);
        return ~vec & (vec + FZ_W'(1));
    endfunction

endpackage

// File: rtl/tlb_victim_alloc_plru.sv
// Tree pseudo-LRU for a fully associative bank: one-hot use in, one-hot victim out.
// Latency: a use updates the tree on the next edge; plru_o is combinational from the tree.
// Backpressure: none; every used_i pulse is absorbed in the cycle it arrives.
module plru_tree #(
    parameter int ENTRIES = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ENTRIES-1:0] used_i,
    output logic [ENTRIES-1:0] plru_o
);

    localparam int LEVELS = $clog2(ENTRIES);

    // Heap-indexed nodes 1..ENTRIES-1 stored at bit k-1. A node bit of 1 means the
    // victim lies in its upper-index half, 0 means the lower-index half.
    logic [ENTRIES-2:0] node_q;
    logic [ENTRIES-2:0] node_d;

    // The tree is deliberately not reset; allocation never consults it until every
    // entry has been filled, and those fills write every node.
    logic unused_rst;
    assign unused_rst = rst;

    // Entries that reach heap node 'node' through its lower (dir=0) or upper (dir=1) child.
    function automatic logic [ENTRIES-1:0] side_mask(input int node, input int dir);
        logic [ENTRIES-1:0] m;
        m = '0;
        for (int e = 0; e < ENTRIES; e++) begin
            for (int l = 0; l < LEVELS; l++) begin
                if ((((ENTRIES + e) >> (l + 1)) == node) && ((((ENTRIES + e) >> l) & 1) == dir)) begin
                    m[e] = 1'b1;
                end
            end
        end
        return m;
    endfunction

    // A use under one half of a node points that node at the other half.
    for (genvar k = 1; k < ENTRIES; k++) begin : g_node
        localparam logic [ENTRIES-1:0] LO_MASK = side_mask(k, 0);
        localparam logic [ENTRIES-1:0] HI_MASK = side_mask(k, 1);
        assign node_d[k-1] = (|(used_i & LO_MASK)) ? 1'b1 :
                             (|(used_i & HI_MASK)) ? 1'b0 : node_q[k-1];
    end

    // An entry is the victim when every node on its root path points toward it.
    for (genvar e = 0; e < ENTRIES; e++) begin : g_pick
        logic [LEVELS-1:0] on_path;
        for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
            localparam int   LEAF = ENTRIES + e;
            localparam int   NODE = LEAF >> (l + 1);
            localparam logic DIR  = (((LEAF >> l) & 1) != 0);
            assign on_path[l] = (node_q[NODE-1] == DIR);
        end
        assign plru_o[e] = &on_path;
    end

    // Tree state register.
    always_ff @(posedge clk) begin
        node_q <= node_d;
    end

endmodule

// File: rtl/tlb_victim_alloc.sv
// Victim allocator: picks lowest invalid entry else PLRU, locks it for the refill engine, tracks valid bits.
// Latency: alloc_req_i -> alloc_ack_o/alloc_way_o/busy_o 1 cycle; fill_done_i -> valid_o 1 cycle.
// Backpressure: one victim outstanding; requests are ignored while busy_o until fill, flush or reset.
module tlb_victim_alloc
    import tlb_alloc_pkg::*;
#(
    parameter int ENTRIES = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               hit_valid_i,
    input  logic [ENTRIES-1:0] hit_way_i,
    input  logic               alloc_req_i,
    output logic               alloc_ack_o,
    output logic [ENTRIES-1:0] alloc_way_o,
    output logic               busy_o,
    input  logic               fill_done_i,
    input  logic               flush_i,
    output logic [ENTRIES-1:0] valid_o
);

    localparam logic [0:0] ST_IDLE = IDLE;
    localparam logic [0:0] ST_LOCK = LOCK;

    logic [0:0]         state_q, state_d;
    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [ENTRIES-1:0] way_q,   way_d;
    logic               ack_q,   ack_d;

    logic [FZ_W-1:0]    fz_in;
    logic [ENTRIES-1:0] free_way;
    logic [ENTRIES-1:0] plru_way;
    logic [ENTRIES-1:0] victim;
    logic [ENTRIES-1:0] hit_masked;
    logic [ENTRIES-1:0] use_vec;
    logic               fill_fire;

    // Pad above ENTRIES with ones so the free search never selects a nonexistent entry.
    always_comb begin
        fz_in = '1;
        fz_in[ENTRIES-1:0] = valid_q;
    end

    assign free_way  = ENTRIES'(first_zero_onehot(fz_in));
    assign victim    = (&valid_q) ? plru_way : free_way;
    assign fill_fire = (state_q == ST_LOCK) && fill_done_i;

    // Hits only count on valid entries, and never on the entry being refilled.
    always_comb begin
        hit_masked = '0;
        if (hit_valid_i) begin
            hit_masked = hit_way_i & valid_q;
            if (state_q == ST_LOCK) begin
                hit_masked = hit_masked & ~way_q;
            end
        end
    end

    // Tree use vector: a completing fill beats a hit; reset and flush suppress both.
    always_comb begin
        use_vec = '0;
        if (!rst && !flush_i) begin
            use_vec = fill_fire ? way_q : hit_masked;
        end
    end

    plru_tree #(
        .ENTRIES (ENTRIES)
    ) u_plru (
        .clk    (clk),
        .rst    (rst),
        .used_i (use_vec),
        .plru_o (plru_way)
    );

    // Allocation FSM; flush clears everything in its cycle and drops coincident requests and fills.
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        way_d   = way_q;
        ack_d   = 1'b0;
        if (flush_i) begin
            valid_d = '0;
            state_d = ST_IDLE;
        end else if (state_q == ST_IDLE) begin
            if (alloc_req_i) begin
                way_d   = victim;
                ack_d   = 1'b1;
                state_d = ST_LOCK;
            end
        end else if (fill_done_i) begin
            valid_d = valid_q | way_q;
            state_d = ST_IDLE;
        end
    end

    // Allocator state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            valid_q <= '0;
            way_q   <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            way_q   <= way_d;
            ack_q   <= ack_d;
        end
    end

    assign alloc_ack_o = ack_q;
    assign alloc_way_o = way_q;
    assign busy_o      = (state_q == ST_LOCK);
    assign valid_o     = valid_q;

endmodule
